// File: rtl/unidade_ou_pipeline.sv
// Two-stage pipelined logic unit (OR/AND/XOR/NOR/OR-reduce/pass) with a sticky OR accumulator.
// Optional macro OU_FLAGS_EN adds registered saida_zero / saida_uns flags.
module unidade_ou_pipeline #(
    parameter int unsigned          LARGURA   = 32,
    parameter logic [LARGURA-1:0]   ACC_RESET = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               entrada_valida,
    output logic               entrada_pronta,
    input  logic [LARGURA-1:0] entrada_a,
    input  logic [LARGURA-1:0] entrada_b,
    input  logic [2:0]         operacao,
    output logic [LARGURA-1:0] saida,
    output logic               saida_valida,
`ifdef OU_FLAGS_EN
    output logic               saida_zero,
    output logic               saida_uns,
`endif
    input  logic               saida_pronta,
    output logic [LARGURA-1:0] acumulador
);

    typedef enum logic [2:0] {
        OP_OU     = 3'b000,
        OP_E      = 3'b001,
        OP_XOU    = 3'b010,
        OP_NOU    = 3'b011,
        OP_OU_ACC = 3'b100,
        OP_LIMPA  = 3'b101,
        OP_RED_OU = 3'b110,
        OP_PASSA  = 3'b111
    } op_t;

    logic               s1_v;
    logic [LARGURA-1:0] s1_a;
    logic [LARGURA-1:0] s1_b;
    op_t                s1_op;

    logic               avanca1;
    logic               avanca2;
    logic [LARGURA-1:0] resultado;
    logic [LARGURA-1:0] acc_prox;

    // saida_valida is the stage-2 valid bit itself
    assign avanca2        = !saida_valida || saida_pronta;
    assign avanca1        = !s1_v || avanca2;
    assign entrada_pronta = avanca1;

    always_comb begin
        resultado = '0;
        acc_prox  = acumulador;
        case (s1_op)
            OP_OU:     resultado = s1_a | s1_b;
            OP_E:      resultado = s1_a & s1_b;
            OP_XOU:    resultado = s1_a ^ s1_b;
            OP_NOU:    resultado = ~(s1_a | s1_b);
            OP_OU_ACC: begin
                acc_prox  = acumulador | s1_a;
                resultado = acc_prox;
            end
            OP_LIMPA:  begin
                acc_prox  = ACC_RESET;
                resultado = ACC_RESET;
            end
            OP_RED_OU: resultado[0] = |s1_a;
            OP_PASSA:  resultado = s1_a;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v  <= 1'b0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_op <= OP_OU;
        end else if (avanca1) begin
            s1_v <= entrada_valida;
            if (entrada_valida) begin
                s1_a  <= entrada_a;
                s1_b  <= entrada_b;
                s1_op <= op_t'(operacao);
            end
        end
    end

    // Accumulator commits only when its op moves into stage 2, so stalls never repeat an update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saida_valida <= 1'b0;
            saida        <= '0;
            acumulador   <= ACC_RESET;
`ifdef OU_FLAGS_EN
            saida_zero   <= 1'b1;
            saida_uns    <= 1'b0;
`endif
        end else if (avanca2) begin
            saida_valida <= s1_v;
            if (s1_v) begin
                saida      <= resultado;
                acumulador <= acc_prox;
`ifdef OU_FLAGS_EN
                saida_zero <= (resultado == '0);
                saida_uns  <= (resultado == '1);
`endif
            end
        end
    end

endmodule
